// File: rtl/vga_mem_arbiter.sv
`timescale 1ns/1ps
// vga_mem_arbiter
// Shares one single-port video RAM between the scanout fetcher and a writer
// port. Scanout reads have priority. A starvation counter forces a writer
// grant after STARVE_MAX cycles of waiting.
//
// Handshakes:
//   pix_*  : a word moves when pix_valid && pix_ready in the same cycle;
//            pix_data is the FIFO head and is stable while pix_valid is high
//            and pix_ready is low.
//   wr_*   : the writer holds wr_req/wr_addr/wr_data until wr_ack, which is
//            high exactly in the cycle the write is presented to the RAM.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   line_start, line_base    start a new line fetch from line_base
//   pix_data/valid/ready     scanout word stream to the colour stage
//   wr_req/addr/data, wr_ack writer port
//   mem_en/we/addr/wdata     RAM command (combinational), mem_rdata 1-cycle later
//   clr_status               clears the sticky flags
//   underrun, line_overrun   sticky error flags
module vga_mem_arbiter #(
  parameter int AW             = 12,
  parameter int DW             = 8,
  parameter int WORDS_PER_LINE = 80,
  parameter int FIFO_DEPTH     = 4,
  parameter int STARVE_MAX     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          line_start,
  input  logic [AW-1:0] line_base,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          clr_status,
  output logic          underrun,
  output logic          line_overrun
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] fetch_addr_q;
  logic [RW-1:0] remaining_q;
  logic          inflight_q, discard_q;
  logic [SW-1:0] starve_q;
  logic          underrun_q, overrun_q;

  logic fetch_elig, starve_full, wr_grant, fd_grant;
  logic push, pop, underrun_set, overrun_set;

  assign pix_valid    = (count_q != '0);
  assign pix_data     = fifo_mem[rd_ptr_q];
  assign underrun     = underrun_q;
  assign line_overrun = overrun_q;

  // Words already fetched but not yet consumed (FIFO plus the read in
  // flight) must leave room, so the read-return push can never overflow.
  // No fetch is issued in a line_start cycle; the writer may use that slot.
  assign fetch_elig  = (state_q == FETCH) && (remaining_q != '0) && !line_start &&
                       ((count_q + CW'(inflight_q)) < DEPTH_C);
  assign starve_full = (starve_q == SW'(STARVE_MAX));
  assign wr_grant    = !rst && wr_req && (starve_full || !fetch_elig);
  assign fd_grant    = !rst && !wr_grant && fetch_elig;

  // Read data returning in a line_start cycle belongs to the old line.
  assign push = inflight_q && !discard_q && !line_start;
  assign pop  = pix_valid && pix_ready;

  assign underrun_set = (state_q == FETCH) && pix_ready && !pix_valid &&
                        ((remaining_q != '0) || inflight_q);
  assign overrun_set  = line_start && (state_q == FETCH) &&
                        ((remaining_q != '0) || inflight_q || (count_q != '0));

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_ack    = 1'b0;
    if (wr_grant) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
      wr_ack    = 1'b1;
    end else if (fd_grant) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (line_start) begin
      state_d = FETCH;
    end else if ((state_q == FETCH) && (remaining_q == '0) && !inflight_q &&
                 (count_q == '0)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO storage needs no reset; pix_valid qualifies the head word.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      fetch_addr_q <= '0;
      remaining_q  <= '0;
      inflight_q   <= 1'b0;
      discard_q    <= 1'b0;
    end else if (line_start) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      fetch_addr_q <= line_base;
      remaining_q  <= RW'(WORDS_PER_LINE);
      inflight_q   <= 1'b0;
      discard_q    <= inflight_q;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
      if (fd_grant) begin
        fetch_addr_q <= fetch_addr_q + AW'(1);
        remaining_q  <= remaining_q - RW'(1);
      end
      inflight_q <= fd_grant;
      discard_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else if (wr_req && !wr_grant) begin
      if (!starve_full) begin
        starve_q <= starve_q + SW'(1);
      end
    end else begin
      starve_q <= '0;
    end
  end

  // A set condition in the same cycle as clr_status wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (underrun_set) begin
        underrun_q <= 1'b1;
      end else if (clr_status) begin
        underrun_q <= 1'b0;
      end
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end else if (clr_status) begin
        overrun_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
`timescale 1ns/1ps
module tb_vga_mem_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int WPL  = 80;
  localparam int DEPTH = 4;
  localparam int SMAX = 8;
  localparam int NCYC = 4000;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          line_start;
  logic [AW-1:0] line_base;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          clr_status;
  logic          underrun;
  logic          line_overrun;

  always #5 clk = ~clk;

  vga_mem_arbiter #(
    .AW(AW), .DW(DW), .WORDS_PER_LINE(WPL), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .line_start(line_start), .line_base(line_base),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .clr_status(clr_status), .underrun(underrun), .line_overrun(line_overrun)
  );

  // ---------------- RAM model ----------------
  logic [DW-1:0] ram [1 << AW];

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  // ---------------- counters / check ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // A line is modelled as the list of addresses base..base+WPL-1 (mod 2^AW)
  // and the RAM words at those addresses; the consumer must see exactly that
  // word sequence, and reads must walk exactly that address list.
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] rd_log[$];
  int            line_reads, line_pops, unacked, mon_pre;
  logic          exp_ov;
  logic [AW-1:0] mon_a;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_addr_q.delete();
      line_reads = 0;
      line_pops  = 0;
      unacked    = 0;
      exp_ov     = 1'b0;
    end else begin
      chk("line_overrun", 32'(line_overrun), 32'(exp_ov));
      if (line_start) chk("no_read_on_line_start", 32'(mem_en && !mem_we), 32'd0);
      if (mem_en && !mem_we && !line_start) begin
        if (exp_addr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rd_unexpected: got read of 0x%0h expected none at %0t", mem_addr, $time);
        end else begin
          chk("rd_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
          chk("fifo_budget", 32'((line_reads - line_pops) < DEPTH), 32'd1);
        end
        rd_log.push_back(mem_addr);
        line_reads++;
      end
      mon_pre = exp_q.size();
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pix_unexpected: got word 0x%0h expected none at %0t", pix_data, $time);
        end else begin
          chk("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
        end
        line_pops++;
      end
      if (wr_ack) begin
        chk("wr_cmd", 32'({mem_en, mem_we}), 32'd3);
        chk("wr_addr", 32'(mem_addr), 32'(wr_addr));
        chk("wr_data", 32'(mem_wdata), 32'(wr_data));
      end
      if (wr_req && !wr_ack) begin
        unacked++;
        chk("starve_bound", 32'(unacked <= SMAX), 32'd1);
      end else begin
        unacked = 0;
      end
      if (line_start && mon_pre > 0) exp_ov = 1'b1;
      else if (clr_status) exp_ov = 1'b0;
      if (line_start) begin
        exp_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < WPL; i++) begin
          mon_a = line_base + AW'(i);
          exp_addr_q.push_back(mon_a);
          exp_q.push_back(ram[mon_a]);
        end
        line_reads = 0;
        line_pops  = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ls(input logic [AW-1:0] base);
    line_start = 1'b1;
    line_base  = base;
    cyc(1);
    line_start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    cyc(1);
    clr_status = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !pix_valid; i++) cyc(1);
    chk(name, 32'(pix_valid), 32'd1);
  endtask

  task automatic wait_line_done(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) cyc(1);
    chk(name, 32'(exp_q.size()), 32'd0);
    cyc(3);
  endtask

  task automatic wr_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    lat     = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (wr_ack) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat == 0) lat = 99;
    @(posedge clk);
    #1;
    wr_req = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          e_en;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_ack;
  } vec_t;

  vec_t vt[6];
  int   lat;
  logic rnd_done;

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    vt[0] = '{1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0};
    vt[1] = '{1'b1, 12'h2A0, 8'h5C, 1'b1, 1'b1, 12'h2A0, 8'h5C, 1'b1};
    vt[2] = '{1'b1, 12'h9A3, 8'hA5, 1'b1, 1'b1, 12'h9A3, 8'hA5, 1'b1};
    vt[3] = '{1'b0, 12'hFFF, 8'hFF, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0};
    vt[4] = '{1'b1, 12'hC00, 8'h00, 1'b1, 1'b1, 12'hC00, 8'h00, 1'b1};
    vt[5] = '{1'b1, 12'h000, 8'hFF, 1'b1, 1'b1, 12'h000, 8'hFF, 1'b1};

    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'(i);
    rst = 1'b1; line_start = 1'b0; line_base = '0; pix_ready = 1'b0;
    wr_req = 1'b1; wr_addr = 12'h123; wr_data = 8'h77; clr_status = 1'b0;
    rnd_done = 1'b0;

    // reset state, with a write request pending
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_flags", 32'({underrun, line_overrun}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // writer in idle: table of single-cycle arbitration vectors
    for (int i = 0; i < 6; i++) begin
      wr_req = vt[i].req; wr_addr = vt[i].addr; wr_data = vt[i].data;
      @(negedge clk);
      chk("tbl_mem_en", 32'(mem_en), 32'(vt[i].e_en));
      chk("tbl_mem_we", 32'(mem_we), 32'(vt[i].e_we));
      chk("tbl_mem_addr", 32'(mem_addr), 32'(vt[i].e_addr));
      chk("tbl_mem_wdata", 32'(mem_wdata), 32'(vt[i].e_wdata));
      chk("tbl_wr_ack", 32'(wr_ack), 32'(vt[i].e_ack));
      chk("tbl_pix_valid", 32'(pix_valid), 32'd0);
      @(posedge clk); #1;
    end
    wr_req = 1'b0;
    chk("ram_2a0", 32'(ram[12'h2A0]), 32'h5C);

    // basic line
    pix_ready = 1'b1;
    rd_log.delete();
    pulse_ls(12'h100);
    wait_valid("basic_first_valid");
    chk("basic_first_word", 32'(pix_data), 32'h00);
    pulse_clr();
    wait_line_done("basic_done");
    chk("basic_underrun", 32'(underrun), 32'd0);
    chk("basic_reads", 32'(rd_log.size()), 32'd80);
    chk("basic_first_addr", 32'(rd_log[0]), 32'h100);
    chk("basic_last_addr", 32'(rd_log[79]), 32'h14F);
    chk("basic_pops", 32'(line_pops), 32'd80);
    chk("basic_fsm_idle", 32'(dut.state_q), 32'd0);
    chk("basic_mem_quiet", 32'(mem_en), 32'd0);

    // fetch of a word written earlier through the writer port
    pulse_ls(12'h2A0);
    wait_valid("wrfetch_valid");
    chk("wrfetch_word", 32'(pix_data), 32'h5C);
    wait_line_done("wrfetch_done");

    // back-pressure
    pix_ready = 1'b0;
    rd_log.delete();
    pulse_ls(12'h000);
    cyc(20);
    chk("bp_reads", 32'(rd_log.size()), 32'd4);
    chk("bp_mem_idle", 32'(mem_en), 32'd0);
    pix_ready = 1'b1;
    wait_line_done("bp_done");
    chk("bp_total_reads", 32'(rd_log.size()), 32'd80);
    chk("bp_pops", 32'(line_pops), 32'd80);

    // starvation: continuous fetch, writer forced in after STARVE_MAX waits
    pulse_ls(12'h200);
    cyc(3);
    wr_txn(12'h900, 8'h11, lat);
    chk("starve_lat1", 32'(lat), 32'(SMAX + 1));
    chk("starve_ram1", 32'(ram[12'h900]), 32'h11);
    wr_txn(12'h901, 8'h22, lat);
    chk("starve_lat2", 32'(lat), 32'(SMAX + 1));
    chk("starve_ram2", 32'(ram[12'h901]), 32'h22);
    wait_line_done("starve_done");

    // early line_start
    pulse_clr();
    pulse_ls(12'h300);
    for (int i = 0; i < 200 && line_pops < 10; i++) cyc(1);
    pulse_ls(12'h800);
    chk("early_overrun", 32'(line_overrun), 32'd1);
    wait_valid("early_valid");
    chk("early_first_word", 32'(pix_data), 32'h00);
    wait_line_done("early_done");
    pulse_clr();
    chk("early_clr", 32'(line_overrun), 32'd0);

    // wrap-around addressing, underrun and clear
    rd_log.delete();
    pulse_ls(12'hFFE);
    wait_valid("wrap_valid");
    cyc(2);
    pulse_clr();
    cyc(2);
    chk("underrun_steady", 32'(underrun), 32'd0);
    chk("wrap_a0", 32'(rd_log[0]), 32'hFFE);
    chk("wrap_a1", 32'(rd_log[1]), 32'hFFF);
    chk("wrap_a2", 32'(rd_log[2]), 32'h000);
    chk("wrap_a3", 32'(rd_log[3]), 32'h001);
    wr_txn(12'hA00, 8'h33, lat);
    cyc(3);
    chk("underrun_set", 32'(underrun), 32'd1);
    pulse_clr();
    chk("underrun_clr", 32'(underrun), 32'd0);
    wait_line_done("wrap_done");

    // reset mid-line
    pulse_ls(12'h400);
    cyc(5);
    #2 rst = 1'b1;
    #1;
    chk("midrst_pix_valid", 32'(pix_valid), 32'd0);
    chk("midrst_mem_en", 32'(mem_en), 32'd0);
    chk("midrst_flags", 32'({underrun, line_overrun}), 32'd0);
    @(posedge clk); #1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    pulse_ls(12'h500);
    wait_valid("midrst_valid");
    chk("midrst_first_word", 32'(pix_data), 32'h00);
    wait_line_done("midrst_done");
    chk("midrst_pops", 32'(line_pops), 32'd80);

    // randomized traffic against the model
    fork
      begin : consumer
        repeat (NCYC) begin
          pix_ready  = ($urandom_range(0, 3) != 0);
          clr_status = ($urandom_range(0, 31) == 0);
          cyc(1);
        end
        rnd_done = 1'b1;
      end
      begin : lines
        while (!rnd_done) begin
          int gap;
          pulse_ls(12'($urandom_range(0, 12'h7B0)));
          gap = $urandom_range(40, 200);
          for (int k = 0; k < gap && !rnd_done; k++) cyc(1);
        end
      end
      begin : writer
        while (!rnd_done) begin
          int idle;
          logic [AW-1:0] a;
          logic [DW-1:0] d;
          int wlat;
          idle = $urandom_range(0, 12);
          for (int k = 0; k < idle && !rnd_done; k++) cyc(1);
          if (!rnd_done) begin
            a = 12'h800 | 12'($urandom_range(0, 12'h7FF));
            d = 8'($urandom);
            wr_txn(a, d, wlat);
            chk("rnd_wr_lat", 32'(wlat <= SMAX + 1), 32'd1);
            chk("rnd_wr_ram", 32'(ram[a]), 32'(d));
          end
        end
      end
    join
    pix_ready  = 1'b1;
    clr_status = 1'b0;
    wait_line_done("rnd_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_mem_arbiter.md
Name: vga_mem_arbiter

Overview:
- Shares one single-port video RAM between two requesters: the scanout fetcher, which feeds pixel words to the VGA pixel path, and a writer port (host/pattern generator).
- Scanout has deadline priority. A starvation counter guarantees the writer a slot.
- Sits between the VGA timing generator (which supplies line_start), the colour output stage (pix_* handshake) and the RAM macro.

Parameters:
- AW, 12: RAM address width.
- DW, 8: RAM data width.
- WORDS_PER_LINE, 80: words fetched per line_start (1..2^AW).
- FIFO_DEPTH, 4: scanout FIFO depth; power of 2, minimum 2.
- STARVE_MAX, 8: writer wait cycles before a forced grant (minimum 1).

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- line_start, in, 1: single-cycle pulse; begins fetch of a new line.
- line_base, in, AW: start address of the line; sampled on line_start.
- pix_data, out, DW: FIFO head word.
- pix_valid, out, 1: FIFO not empty.
- pix_ready, in, 1: consumer takes the word when pix_valid and pix_ready are both high.
- wr_req, in, 1: writer request; held high until ack.
- wr_addr, in, AW: write address; held stable while wr_req is high.
- wr_data, in, DW: write data; held stable while wr_req is high.
- wr_ack, out, 1: combinational; high in the cycle the write is issued to RAM.
- mem_en, out, 1: RAM access strobe.
- mem_we, out, 1: 1 = write, 0 = read.
- mem_addr, out, AW: RAM address.
- mem_wdata, out, DW: RAM write data.
- mem_rdata, in, DW: read data, valid the cycle after a read.
- clr_status, in, 1: clears both sticky flags.
- underrun, out, 1: sticky; consumer starved mid-line.
- line_overrun, out, 1: sticky; line_start arrived before the previous line finished.

Behaviour:
- Reset: async. State IDLE, FIFO empty, remaining=0, inflight=0, discard=0, starve_cnt=0, both flags 0, all mem_* and wr_ack 0, pix_valid 0.
- FSM has two states.
  - IDLE: no fetch pending.
  - FETCH: remaining>0 or inflight=1.
  - FETCH -> IDLE when remaining=0, inflight=0 and FIFO empty.
- line_start in any state: fetch_addr<=line_base, remaining<=WORDS_PER_LINE, FIFO flushed, state<=FETCH.
  - If an inflight read exists, set discard so its data is dropped next cycle.
  - If line_start arrives in FETCH with undelivered words (remaining>0, inflight, or FIFO non-empty), set line_overrun.
  - No fetch read is issued in the line_start cycle; writer arbitration proceeds normally.
- Fetch eligibility: state FETCH, remaining>0, and fifo_count+inflight < FIFO_DEPTH.
- Arbitration: one RAM access per cycle; mem_* outputs are combinational from registered state and wr_*.
  - Writer is granted if wr_req and (starve_cnt==STARVE_MAX or not fetch-eligible).
  - Otherwise fetch is granted if eligible.
  - Writer grant: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
  - Fetch grant: mem_en=1, mem_we=0, mem_addr=fetch_addr. Then fetch_addr<=fetch_addr+1 (wraps mod 2^AW), remaining--, inflight<=1.
  - No grant: mem_en=0, mem_we=0, mem_addr and mem_wdata=0.
- Starvation counter:
  - starve_cnt increments, saturating at STARVE_MAX, on each cycle wr_req=1 without wr_ack.
  - It clears to 0 on wr_ack or when wr_req=0.
  - A forced grant therefore occurs at most STARVE_MAX+1 cycles after the request is raised.
- Read return: the cycle after a fetch read, mem_rdata is pushed into the FIFO unless discard is set. inflight and discard then clear.
  - Fetch eligibility guarantees the push never overflows.
- FIFO: first-word-fall-through (pix_data = head). Simultaneous push and pop is legal; count is unchanged.
- underrun: set when state=FETCH, pix_ready=1, pix_valid=0 and (remaining>0 or inflight=1).
- Sticky flags: clr_status clears both; a set condition in the same cycle wins over clr.
- Reset asserted mid-line: everything returns to reset values immediately; the next line_start restarts cleanly.

Test Plan:
- Basic line: line_base=0x100, WORDS_PER_LINE=80, RAM preloaded with addr[7:0], pix_ready=1 -> 80 words 0x00..0x4F appear in order; mem reads on 0x100..0x14F; underrun stays 0 after the first word; FSM returns to IDLE.
- Back-pressure: pix_ready=0 after line_start -> exactly 4 reads issue and mem_en then stays 0. Release pix_ready -> fetch resumes, no data lost or duplicated.
- Starvation: wr_req held high during fetch with pix_ready=1 -> wr_ack within 9 cycles, RAM written at wr_addr. Repeat the request -> guaranteed again within 9 cycles.
- Writer in idle: FSM IDLE, wr_req with addr 0x2A0, data 0x5C -> wr_ack and mem_we the same cycle; a later fetch of 0x2A0 returns 0x5C.
- Early line_start: second pulse with line_base=0x800 after 10 words -> line_overrun=1; FIFO flushed; inflight word dropped; next pix_data = RAM[0x800].
- Underrun/clear and wrap: line_base=0xFFE, 4 words -> addresses 0xFFE, 0xFFF, 0x000, 0x001. Hold pix_ready=1 while the FIFO empties mid-line -> underrun=1. Pulse clr_status -> underrun=0.
